// File: rtl/cfu_channel_sequencer_pkg.sv
// Shared definitions for the CFU channel sequencer: FSM state
// encoding, quantizer control codes and the strobe bundle type.
package cfu_channel_sequencer_pkg;

    // Encoded FSM states
    localparam logic [2:0] SEQ_IDLE  = 3'd0;
    localparam logic [2:0] SEQ_CLEAR = 3'd1;
    localparam logic [2:0] SEQ_MAC   = 3'd2;
    localparam logic [2:0] SEQ_DRAIN = 3'd3;
    localparam logic [2:0] SEQ_QNT   = 3'd4;
    localparam logic [2:0] SEQ_WAIT  = 3'd5;
    localparam logic [2:0] SEQ_HOLD  = 3'd6;

    // Quantizer control codes
    localparam logic [1:0] QNT_CTRL_IDLE   = 2'b00;
    localparam logic [1:0] QNT_CTRL_STAGE1 = 2'b01;

    // Latency counter width; holds QNT_LATENCY in 1..15
    localparam int LAT_W = 4;

    // Combinational datapath strobes driven by the sequencer
    typedef struct packed {
        logic       buf_read_en;
        logic       buf_reappend_en;
        logic       acc_add;
        logic       wgt_ready;
        logic       acc_clear;
        logic [1:0] qnt_control;
    } seq_strobe_t;

    // All strobes inactive
    function automatic seq_strobe_t seq_strobe_none();
        seq_strobe_t s;
        s             = '0;
        s.qnt_control = QNT_CTRL_IDLE;
        return s;
    endfunction

endpackage

// File: rtl/cfu_seq_counter.sv
// Loadable down-counter with zero and one flags.
// Ports: clk, reset (async high), load_i/load_val_i load a new
// value, dec_i decrements (saturating at 0), zero_o = count==0,
// one_o = count==1.
module cfu_seq_counter #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o,
    output logic         one_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load wins over decrement; never wraps below zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);
    assign one_o  = (cnt_q == W'(1));

endmodule

// File: rtl/cfu_channel_sequencer.sv
// Sequences one output-channel computation: accumulator clear,
// N buffered MAC steps, quantizer strobe + fixed wait, and result
// presentation on a valid/ready port.
// Ports: start/start_len/abort command in, busy/done status out;
// buf_* and wgt_* handshake the activation buffer and weight
// stream; acc_add/acc_clear/qnt_control drive the datapath;
// qnt_data is captured into res_data (res_valid/res_ready);
// steps_done counts MAC steps fired in the current channel.
module cfu_channel_sequencer
    import cfu_channel_sequencer_pkg::*;
#(
    parameter int LEN_W       = 9,
    parameter int QNT_LATENCY = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] start_len,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    input  logic             buf_read_valid,
    output logic             buf_read_en,
    output logic             buf_reappend_en,
    input  logic             wgt_valid,
    output logic             wgt_ready,
    output logic             acc_add,
    output logic             acc_clear,
    output logic [1:0]       qnt_control,
    input  logic [31:0]      qnt_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic [LEN_W-1:0] steps_done
);

    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic [LEN_W-1:0] steps_q;
    logic [LEN_W-1:0] steps_d;
    logic [31:0]      res_data_q;
    logic [31:0]      res_data_d;

    logic        accept;
    logic        abort_hit;
    logic        fire;
    logic        capture;
    logic        rem_zero;
    logic        rem_one;
    logic        lat_zero;
    logic        lat_one_unused;
    seq_strobe_t strb;

    assign accept    = start & (state_q == SEQ_IDLE);
    assign abort_hit = abort & (state_q != SEQ_IDLE);

    // Abort outranks a MAC step in the same cycle
    assign fire = (state_q == SEQ_MAC) & buf_read_valid
                & wgt_valid & ~abort;

    // Remaining MAC steps for this channel
    cfu_seq_counter #(
        .W(LEN_W)
    ) u_rem (
        .clk       (clk),
        .reset     (reset),
        .load_i    (accept),
        .load_val_i(start_len),
        .dec_i     (fire),
        .zero_o    (rem_zero),
        .one_o     (rem_one)
    );

    // Quantizer wait: loaded with LATENCY-1 so that leaving WAIT
    // at zero puts res_valid LATENCY cycles after the QNT cycle+1,
    // i.e. the capture edge is exactly LATENCY after the strobe.
    cfu_seq_counter #(
        .W(LAT_W)
    ) u_lat (
        .clk       (clk),
        .reset     (reset),
        .load_i    (state_q == SEQ_QNT),
        .load_val_i(LAT_W'(QNT_LATENCY - 1)),
        .dec_i     (state_q == SEQ_WAIT),
        .zero_o    (lat_zero),
        .one_o     (lat_one_unused)
    );

    assign capture = (state_q == SEQ_WAIT) & lat_zero & ~abort;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SEQ_IDLE: begin
                if (start) begin
                    state_d = SEQ_CLEAR;
                end
            end
            SEQ_CLEAR: begin
                state_d = rem_zero ? SEQ_DRAIN : SEQ_MAC;
            end
            SEQ_MAC: begin
                if (fire && rem_one) begin
                    state_d = SEQ_DRAIN;
                end
            end
            SEQ_DRAIN: begin
                state_d = SEQ_QNT;
            end
            SEQ_QNT: begin
                state_d = SEQ_WAIT;
            end
            SEQ_WAIT: begin
                if (lat_zero) begin
                    state_d = SEQ_HOLD;
                end
            end
            SEQ_HOLD: begin
                if (res_ready) begin
                    state_d = SEQ_IDLE;
                end
            end
            default: begin
                state_d = SEQ_IDLE;
            end
        endcase
        if (abort_hit) begin
            state_d = SEQ_IDLE;
        end
    end

    // Datapath strobes: abort issues only the accumulator clear
    always_comb begin
        strb = seq_strobe_none();
        if (abort_hit) begin
            strb.acc_clear = 1'b1;
        end else begin
            if (state_q == SEQ_CLEAR) begin
                strb.acc_clear = 1'b1;
            end
            if (fire) begin
                strb.buf_read_en     = 1'b1;
                strb.buf_reappend_en = 1'b1;
                strb.acc_add         = 1'b1;
                strb.wgt_ready       = 1'b1;
            end
            if (state_q == SEQ_QNT) begin
                strb.qnt_control = QNT_CTRL_STAGE1;
            end
        end
    end

    always_comb begin
        steps_d = steps_q;
        if (accept) begin
            steps_d = '0;
        end else if (fire) begin
            steps_d = steps_q + LEN_W'(1);
        end
    end

    always_comb begin
        res_data_d = res_data_q;
        if (capture) begin
            res_data_d = qnt_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= SEQ_IDLE;
            steps_q    <= '0;
            res_data_q <= '0;
        end else begin
            state_q    <= state_d;
            steps_q    <= steps_d;
            res_data_q <= res_data_d;
        end
    end

    assign buf_read_en     = strb.buf_read_en;
    assign buf_reappend_en = strb.buf_reappend_en;
    assign acc_add         = strb.acc_add;
    assign wgt_ready       = strb.wgt_ready;
    assign acc_clear       = strb.acc_clear;
    assign qnt_control     = strb.qnt_control;

    assign busy       = (state_q != SEQ_IDLE);
    assign res_valid  = (state_q == SEQ_HOLD);
    assign done       = res_valid & res_ready & ~abort;
    assign res_data   = res_data_q;
    assign steps_done = steps_q;

endmodule
